regfile_dump_monitor: RTL and testbench

- Synthesizable end-of-program monitor for the MIPS core. Replaces fixed-delay simulation dumps.
- Watches the program counter and detects halt when PC is unchanged for a configurable number of cycles, or when a cycle budget times out.
- After halt or timeout, emits the final PC and then every register-file entry, one word per valid/ready handshake.
- Sits beside the CPU, on a spare register-file read port.

---
 rtl/regfile_dump_monitor.sv | 157 +++++++++++++++
 tb/tb_regfile_dump_monitor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_monitor.sv
// End-of-program monitor: detects CPU halt (stable PC) or a cycle-budget timeout, then
// streams the final PC and every register over valid/ready. Optional macro: DUMP_SKIP_ZERO_EN.
module regfile_dump_monitor #(
  parameter int DATA_W        = 32,
  parameter int NREGS         = 32,
  parameter int ADDR_W        = 5,
  parameter int PC_W          = 32,
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_CYCLES    = 8192
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PC_W-1:0]   pc,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_kind,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              timed_out
);

  localparam int CYC_W = $clog2(MAX_CYCLES + 1);
  localparam int STB_W = $clog2(STABLE_CYCLES);
  localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(MAX_CYCLES - 1);
  localparam logic [STB_W-1:0]  STB_HALT = STB_W'(STABLE_CYCLES - 2);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NREGS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WATCH, S_DUMP_PC, S_FETCH, S_HOLD, S_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [PC_W-1:0]     pc_q_reg;
  logic [STB_W-1:0]    stable_cnt_reg;
  logic [CYC_W-1:0]    cyc_cnt_reg;
  logic [ADDR_W-1:0]   idx_reg;
  logic [DATA_W-1:0]   data_reg;
  logic [DATA_W-1:0]   final_pc_reg;
  logic                timed_out_reg;

  logic pc_same, halt_hit, timeout_hit, handshake, idx_last, skip_word;
  logic [DATA_W-1:0] pc_word;

  assign pc_same     = (pc == pc_q_reg);
  assign halt_hit    = pc_same && (stable_cnt_reg == STB_HALT);
  assign timeout_hit = (cyc_cnt_reg == CYC_LAST);
  assign handshake   = out_valid && out_ready;
  assign idx_last    = (idx_reg == IDX_LAST);
  assign pc_word     = DATA_W'(pc);

`ifdef DUMP_SKIP_ZERO_EN
  // The last register is always shown so out_last appears exactly once.
  assign skip_word = (rf_rdata == '0) && !idx_last;
`else
  assign skip_word = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start) state_next = S_WATCH;
      S_WATCH:   if (halt_hit || timeout_hit) state_next = S_DUMP_PC;
      S_DUMP_PC: if (handshake) state_next = S_FETCH;
      S_FETCH:   state_next = skip_word ? S_FETCH : S_HOLD;
      S_HOLD:    if (handshake) state_next = idx_last ? S_DONE : S_FETCH;
      S_DONE:    if (start) state_next = S_WATCH;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q_reg       <= '0;
      stable_cnt_reg <= '0;
      cyc_cnt_reg    <= '0;
      idx_reg        <= '0;
      data_reg       <= '0;
      final_pc_reg   <= '0;
      timed_out_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc_q_reg       <= pc;
            stable_cnt_reg <= '0;
            cyc_cnt_reg    <= '0;
            timed_out_reg  <= 1'b0;
          end
        end
        S_WATCH: begin
          pc_q_reg       <= pc;
          cyc_cnt_reg    <= cyc_cnt_reg + CYC_W'(1);
          stable_cnt_reg <= pc_same ? stable_cnt_reg + STB_W'(1) : '0;
          // Halt takes priority when both conditions land on the same cycle.
          if (halt_hit || timeout_hit) begin
            final_pc_reg  <= pc_word;
            timed_out_reg <= !halt_hit;
          end
        end
        S_DUMP_PC: if (handshake) idx_reg <= '0;
        S_FETCH: begin
          data_reg <= rf_rdata;
          if (skip_word) idx_reg <= idx_reg + ADDR_W'(1);
        end
        S_HOLD: begin
          // Return the read address to 0 once the dump finishes.
          if (handshake) idx_reg <= idx_last ? '0 : idx_reg + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rf_raddr  = idx_reg;
  assign timed_out = timed_out_reg;

  always_comb begin
    out_valid = 1'b0;
    out_kind  = 1'b0;
    out_idx   = '0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_reg)
      S_WATCH: busy = 1'b1;
      S_DUMP_PC: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = final_pc_reg;
      end
      S_FETCH: busy = 1'b1;
      S_HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_kind  = 1'b1;
        out_idx   = idx_reg;
        out_data  = data_reg;
        out_last  = idx_last;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump_monitor.sv
// Bench for regfile_dump_monitor: a directed vector table, then scenario runs checked
// against a sample-history halt/timeout model and an expected-word queue.
module tb_regfile_dump_monitor;
  localparam int DW = 32, NR = 32, AW = 5, PW = 32, SC = 4, MC = 64;

  logic clk = 1'b0;
  logic reset, start, out_ready;
  logic [PW-1:0] pc;
  logic [AW-1:0] rf_raddr, out_idx;
  logic [DW-1:0] rf_rdata, out_data;
  logic out_valid, out_kind, out_last, busy, done, timed_out;
  logic [DW-1:0] rf [NR];

  int n_vec = 0;
  int n_err = 0;

  assign rf_rdata = rf[rf_raddr];

  regfile_dump_monitor #(
    .DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .PC_W(PW),
    .STABLE_CYCLES(SC), .MAX_CYCLES(MC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_idx(out_idx), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic rst, st, rdy;
    logic [31:0] pcv;
    logic v, k;
    logic [4:0] ix;
    logic [31:0] d;
    logic l, b, dn, to;
    logic [4:0] ra;
  } vec_t;

  typedef struct packed {
    logic kind;
    logic [4:0] idx;
    logic [31:0] data;
    logic last;
  } word_t;

  function automatic vec_t mk(logic rst, logic st, logic rdy, logic [31:0] p,
                              logic v, logic k, logic [4:0] ix, logic [31:0] d,
                              logic l, logic b, logic dn, logic to, logic [4:0] ra);
    vec_t r;
    r.rst = rst; r.st = st; r.rdy = rdy; r.pcv = p;
    r.v = v; r.k = k; r.ix = ix; r.d = d; r.l = l; r.b = b; r.dn = dn; r.to = to; r.ra = ra;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] all_outs();
    return {out_valid, out_kind, out_idx, out_data, out_last, busy, done, timed_out, rf_raddr};
  endfunction

  // PC source: 0 = ramp by 4 for nsteps samples then hold, 1 = +1 every cycle, 2 = random hops.
  function automatic logic [31:0] gen_pc(int mode, int nsteps, int k, logic [31:0] base,
                                         logic [31:0] prev);
    if (mode == 0) return 32'(4 * ((k < nsteps) ? k : nsteps));
    if (mode == 1) return base + 32'(k);
    if (k == 0 || $urandom_range(0, 2) == 0) return 32'($urandom_range(0, 3) * 4);
    return prev;
  endfunction

  task automatic run_dump(input int mode, input int nsteps, input int stall_idx,
                          input int reset_idx, input bit rnd, input string tag);
    logic [31:0] base, cur_pc, last_pc, exp_pc;
    int eq_run, ncyc, stall_cnt, cycles;
    bit exp_to, finished, prev_valid, prev_ready, prev_hs, rdy, hs, was_last;
    logic [38:0] cur, prev_cur;
    word_t q[$];
    word_t w;

    base = $urandom;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b0;
    cur_pc = gen_pc(mode, nsteps, 0, base, 32'h0);
    pc = cur_pc;
    last_pc = cur_pc;
    eq_run = 1;
    ncyc = 0;
    exp_to = 1'b0;
    exp_pc = '0;
    @(posedge clk);

    // Halt = SC equal consecutive samples; timeout = MC watch samples without halt.
    while (1) begin
      @(negedge clk);
      start = 1'b0;
      chk({tag, ":watch"}, {busy, done, out_valid, timed_out, rf_raddr}, {4'b1000, 5'd0});
      ncyc++;
      cur_pc = gen_pc(mode, nsteps, ncyc, base, last_pc);
      pc = cur_pc;
      eq_run = (cur_pc == last_pc) ? eq_run + 1 : 1;
      last_pc = cur_pc;
      if (eq_run >= SC || ncyc == MC) begin
        exp_to = (eq_run < SC);
        exp_pc = cur_pc;
        break;
      end
      @(posedge clk);
    end
    @(posedge clk);

    w.kind = 1'b0; w.idx = '0; w.data = exp_pc; w.last = 1'b0;
    q.push_back(w);
    for (int i = 0; i < NR; i++) begin
`ifdef DUMP_SKIP_ZERO_EN
      if (rf[i] == 0 && i != NR - 1) continue;
`endif
      w.kind = 1'b1; w.idx = 5'(i); w.data = rf[i]; w.last = (i == NR - 1);
      q.push_back(w);
    end

    prev_valid = 0; prev_ready = 0; prev_hs = 0; prev_cur = '0;
    stall_cnt = 0; cycles = 0; finished = 0;
    while (cycles < 3000 && !finished) begin
      @(negedge clk);
      cur = {out_valid, out_kind, out_idx, out_data, out_last};
      if (cycles == 0) chk({tag, ":pc_word_timing"}, {out_valid, out_kind}, 2'b10);
      cycles++;
      if (prev_valid && !prev_ready) chk({tag, ":hold_stable"}, cur, prev_cur);
      if (prev_hs) chk({tag, ":gap_after_handshake"}, out_valid, 1'b0);
      chk({tag, ":status"}, {busy, done, timed_out}, {2'b10, exp_to});
      if (out_valid) begin
        if (q.size() == 0) chk({tag, ":extra_word"}, out_valid, 1'b0);
        else chk({tag, ":word"}, {out_kind, out_idx, out_data, out_last, rf_raddr},
                 {q[0].kind, q[0].idx, q[0].data, q[0].last, q[0].idx});
      end
      if (out_valid && out_kind && int'(out_idx) == reset_idx) begin
        reset = 1'b1;
        out_ready = 1'b0;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ":reset_mid_dump"}, all_outs(), 48'h0);
        reset = 1'b0;
        return;
      end
      if (out_valid && out_kind && int'(out_idx) == stall_idx && stall_cnt < 5) begin
        rdy = 1'b0;
        stall_cnt++;
      end else begin
        rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      out_ready = rdy;
      pc = $urandom;
      start = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      hs = out_valid && rdy;
      was_last = 1'b0;
      if (hs && q.size() > 0) begin
        was_last = q[0].last;
        void'(q.pop_front());
      end
      prev_valid = out_valid; prev_ready = rdy; prev_hs = hs; prev_cur = cur;
      if (hs && was_last) finished = 1'b1;
    end
    start = 1'b0;
    chk({tag, ":dump_completed"}, {finished, 32'(q.size())}, {1'b1, 32'd0});
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ":done_state"}, {done, busy, out_valid, timed_out, rf_raddr},
        {3'b100, exp_to, 5'd0});
    $display("run %s: timed_out=%0b final_pc=%0h", tag, exp_to, exp_pc);
  endtask

  vec_t tbl [15];

  initial begin
    tbl[0]  = mk(0, 1, 0, 32'h0,  0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 32'h4,  0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 32'h8,  0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 32'hC,  0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 32'h10, 1, 0, 0, 32'h10, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 32'h10, 1, 0, 0, 32'h10, 0, 1, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 32'h55, 1, 0, 0, 32'h10, 0, 1, 0, 0, 0);
    tbl[10] = mk(0, 0, 1, 32'h55, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 32'h55, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[12] = mk(0, 0, 1, 32'h55, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 32'h55, 1, 1, 1, 32'h11, 0, 1, 0, 0, 1);
    tbl[14] = mk(1, 0, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NR; i++) rf[i] = 32'(i * 32'h11);
    reset = 1'b1; start = 1'b0; pc = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", all_outs(), 48'h0);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      reset = tbl[i].rst; start = tbl[i].st; pc = tbl[i].pcv; out_ready = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("tbl[%0d]", i), all_outs(),
          {tbl[i].v, tbl[i].k, tbl[i].ix, tbl[i].d, tbl[i].l, tbl[i].b, tbl[i].dn,
           tbl[i].to, tbl[i].ra});
      $display("vector %0d: pc=%0h valid=%0b data=%0h", i, tbl[i].pcv, out_valid, out_data);
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0; out_ready = 1'b0;

    run_dump(0, 4, -1, -1, 0, "full_dump");
    run_dump(0, 4, 7, -1, 0, "backpressure");
    run_dump(1, 0, -1, -1, 1, "timeout");
    run_dump(0, 61, -1, -1, 0, "halt_wins_tie");
    run_dump(0, 62, -1, -1, 0, "timeout_just_before_halt");
    run_dump(0, 4, -1, 12, 0, "reset_mid");
    run_dump(2, 0, -1, -1, 1, "after_reset");

    for (int i = 0; i < NR; i++) rf[i] = '0;
    rf[2] = 32'd5;
    rf[9] = 32'd7;
    run_dump(0, 4, -1, -1, 0, "sparse_rf");

    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < NR; i++) rf[i] = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
      run_dump((r % 4 == 3) ? 1 : 2, 0, $urandom_range(0, 40), -1, 1, $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
